// File: rtl/div_seq.sv
// Sequential radix-2 restoring signed divider with valid/ready handshakes on both sides.
// Define DIV_SAT_EN to saturate the overflow quotient instead of wrapping it.
module div_seq #(
  parameter int DW = 15,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_quot,
  output logic [VW-1:0] o_rem,
  output logic          o_dz,
  output logic          o_ovf
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] quo;    // dividend magnitude shifts out, quotient bits shift in
  logic [VW:0]   rem;    // one bit wider than VW so a divisor of -2^(VW-1) works
  logic [VW-1:0] dmag;
  logic          neg_q;
  logic          neg_r;

  // Magnitudes of the incoming operands, taken at the accepting edge.
  logic [DW-1:0] dividend_mag;
  logic [VW-1:0] divisor_mag;

  // One restoring step.
  logic [VW:0]   shifted;
  logic [VW+1:0] diff;
  logic          take;
  logic [VW:0]   rem_next;
  logic [DW-1:0] quo_next;

  // Sign correction and overflow.
  logic [DW-1:0] q_signed;
  logic [VW-1:0] r_signed;
  logic          ovf;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    dividend_mag = i_dividend[DW-1] ? -i_dividend : i_dividend;
    divisor_mag  = i_divisor[VW-1]  ? -i_divisor  : i_divisor;

    shifted  = {rem[VW-1:0], quo[DW-1]};
    diff     = {1'b0, shifted} - {2'b00, dmag};
    take     = ~diff[VW+1];
    rem_next = take ? diff[VW:0] : shifted;
    quo_next = {quo[DW-2:0], take};

    q_signed = neg_q ? -quo : quo;
    r_signed = neg_r ? -rem[VW-1:0] : rem[VW-1:0];
    // A positive quotient with its top bit set only arises from -2^(DW-1) / -1.
    ovf      = ~neg_q & quo[DW-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all state, including datapath registers, is cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dmag    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      o_quot  <= '0;
      o_rem   <= '0;
      o_dz    <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            o_ready <= 1'b0;
            cnt     <= '0;
            quo     <= dividend_mag;
            rem     <= '0;
            dmag    <= divisor_mag;
            neg_q   <= i_dividend[DW-1] ^ i_divisor[VW-1];
            neg_r   <= i_dividend[DW-1];
            if (i_divisor == '0) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_quot  <= i_dividend[DW-1] ? Q_MIN : Q_MAX;
              o_rem   <= '0;
              o_dz    <= 1'b1;
              o_ovf   <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          quo <= quo_next;
          rem <= rem_next;
          if (cnt == CW'(DW - 1)) begin
            state <= SIGN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SIGN: begin
          state   <= DONE;
          o_valid <= 1'b1;
          o_dz    <= 1'b0;
          o_ovf   <= ovf;
          if (ovf) begin
`ifdef DIV_SAT_EN
            o_quot <= Q_MAX;
`else
            o_quot <= Q_MIN;
`endif
            o_rem  <= '0;
          end else begin
            o_quot <= q_signed;
            o_rem  <= r_signed;
          end
        end

        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: arithmetic, boundaries, zero divisor,
// result hold under back-pressure, and asynchronous reset in mid-calculation.
module tb_div_seq;

  localparam int DW = 15;
  localparam int VW = 8;
  localparam int MAX_EDGES = 40;
`ifdef DIV_SAT_EN
  localparam logic [DW-1:0] OVF_Q = 15'h3FFF;
`else
  localparam logic [DW-1:0] OVF_Q = 15'h4000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_dividend;
  logic [VW-1:0] i_divisor;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_quot;
  logic [VW-1:0] o_rem;
  logic          o_dz;
  logic          o_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq #(.DW(DW), .VW(VW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_quot     (o_quot),
    .o_rem      (o_rem),
    .o_dz       (o_dz),
    .o_ovf      (o_ovf)
  );

  always #5 clk = ~clk;

  // Present one operand pair, return the number of edges (accept edge = 1) until o_valid.
  task automatic run_op(input int dvd, input int dvs, output int edges);
    @(negedge clk);
    i_dividend = DW'(dvd);
    i_divisor  = VW'(dvs);
    i_valid    = 1'b1;
    @(posedge clk);
    #1;
    i_valid    = 1'b0;
    i_dividend = '1;
    i_divisor  = 8'h5A;
    edges = 1;
    while (o_valid !== 1'b1 && edges < MAX_EDGES) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({o_ready, o_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_handshake: ready/valid got %b want 10", {o_ready, o_valid});
    end
    n_cmp++;
    if ({o_quot, o_rem, o_dz, o_ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: quot=%0d rem=%0d dz=%b ovf=%b want all 0",
               $signed(o_quot), $signed(o_rem), o_dz, o_ovf);
    end
  endtask

  task automatic test_basic();
    int edges;
    run_op(-100, 7, edges);
    n_cmp++;
    if (edges != 17) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d edges want 17", edges);
    end
    n_cmp++;
    if (o_quot !== DW'(-14)) begin
      n_bad++;
      $display("FAIL basic_quot: got %0d want -14", $signed(o_quot));
    end
    n_cmp++;
    if (o_rem !== VW'(-2)) begin
      n_bad++;
      $display("FAIL basic_rem: got %0d want -2", $signed(o_rem));
    end
    n_cmp++;
    if ({o_dz, o_ovf, o_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL basic_flags: dz/ovf/ready got %b want 000", {o_dz, o_ovf, o_ready});
    end
    consume();
  endtask

  task automatic test_boundary();
    int edges;
    run_op(16383, 127, edges);
    n_cmp++;
    if ({o_quot, o_rem} !== {DW'(129), VW'(0)} || edges != 17) begin
      n_bad++;
      $display("FAIL big_dividend: quot=%0d rem=%0d edges=%0d want 129 0 17",
               $signed(o_quot), $signed(o_rem), edges);
    end
    consume();

    run_op(100, -128, edges);
    n_cmp++;
    if ({o_quot, o_rem} !== {DW'(0), VW'(100)}) begin
      n_bad++;
      $display("FAIL min_divisor: quot=%0d rem=%0d want 0 100", $signed(o_quot), $signed(o_rem));
    end
    consume();

    run_op(-16384, -1, edges);
    n_cmp++;
    if ({o_ovf, o_dz} !== 2'b10) begin
      n_bad++;
      $display("FAIL ovf_flag: ovf/dz got %b want 10", {o_ovf, o_dz});
    end
    n_cmp++;
    if ({o_quot, o_rem} !== {OVF_Q, VW'(0)} || edges != 17) begin
      n_bad++;
      $display("FAIL ovf_value: quot=%0d rem=%0d edges=%0d want %0d 0 17",
               $signed(o_quot), $signed(o_rem), edges, $signed(OVF_Q));
    end
    consume();

    run_op(-7, 2, edges);
    n_cmp++;
    if ({o_quot, o_rem, o_ovf} !== {DW'(-3), VW'(-1), 1'b0}) begin
      n_bad++;
      $display("FAIL neg_odd: quot=%0d rem=%0d ovf=%b want -3 -1 0",
               $signed(o_quot), $signed(o_rem), o_ovf);
    end
    consume();
  endtask

  task automatic test_zero_div();
    int edges;
    run_op(55, 0, edges);
    n_cmp++;
    if (edges != 1) begin
      n_bad++;
      $display("FAIL dz_latency: got %0d edges want 1", edges);
    end
    n_cmp++;
    if ({o_dz, o_ovf, o_quot, o_rem} !== {1'b1, 1'b0, DW'(16383), VW'(0)}) begin
      n_bad++;
      $display("FAIL dz_pos: dz=%b ovf=%b quot=%0d rem=%0d want 1 0 16383 0",
               o_dz, o_ovf, $signed(o_quot), $signed(o_rem));
    end
    consume();

    run_op(-5, 0, edges);
    n_cmp++;
    if ({o_dz, o_quot, o_rem} !== {1'b1, DW'(-16384), VW'(0)} || edges != 1) begin
      n_bad++;
      $display("FAIL dz_neg: dz=%b quot=%0d rem=%0d edges=%0d want 1 -16384 0 1",
               o_dz, $signed(o_quot), $signed(o_rem), edges);
    end
    consume();
  endtask

  task automatic test_hold();
    int edges;
    run_op(1000, -9, edges);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_valid    = (k % 2 == 0);
      i_dividend = DW'(7);
      i_divisor  = VW'(1);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({o_valid, o_ready, o_quot, o_rem, o_dz} !== {1'b1, 1'b0, DW'(-111), VW'(1), 1'b0}) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b quot=%0d rem=%0d want 1 0 -111 1",
                 k, o_valid, o_ready, $signed(o_quot), $signed(o_rem));
      end
    end
    i_valid = 1'b0;
    consume();
    n_cmp++;
    if ({o_valid, o_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL hold_release: valid/ready got %b want 01", {o_valid, o_ready});
    end
    n_cmp++;
    if ({o_quot, o_rem} !== {DW'(-111), VW'(1)}) begin
      n_bad++;
      $display("FAIL hold_idle_outputs: quot=%0d rem=%0d want -111 1",
               $signed(o_quot), $signed(o_rem));
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    @(negedge clk);
    i_dividend = DW'(12345);
    i_divisor  = VW'(11);
    i_valid    = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    n_cmp++;
    if ({o_ready, o_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_busy: ready/valid got %b want 00", {o_ready, o_valid});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_ready, o_valid, o_quot, o_rem, o_dz, o_ovf} !== {1'b1, 1'b0, {(DW+VW+2){1'b0}}}) begin
      n_bad++;
      $display("FAIL mid_reset: ready=%b valid=%b quot=%0d rem=%0d dz=%b ovf=%b want 1 0 0 0 0 0",
               o_ready, o_valid, $signed(o_quot), $signed(o_rem), o_dz, o_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(20, 3, edges);
    n_cmp++;
    if ({o_quot, o_rem} !== {DW'(6), VW'(2)} || edges != 17) begin
      n_bad++;
      $display("FAIL post_reset_op: quot=%0d rem=%0d edges=%0d want 6 2 17",
               $signed(o_quot), $signed(o_rem), edges);
    end
    consume();
  endtask

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_boundary();
    test_zero_div();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter DW, default 15, sets dividend and quotient width; it matches the multiplier product width.
REQ-002 Parameter VW, default 8, sets divisor and remainder width; it matches the multiplier operand width.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  operands valid.
REQ-006 o_ready  output  1  block idle and able to accept operands.
REQ-007 i_dividend  input  DW  two's-complement dividend.
REQ-008 i_divisor  input  VW  two's-complement divisor.
REQ-009 o_valid  output  1  result valid; held until consumed.
REQ-010 i_ready  input  1  downstream consumes the result.
REQ-011 o_quot  output  DW  two's-complement quotient, truncated toward zero.
REQ-012 o_rem  output  VW  two's-complement remainder; its sign follows the dividend, or it is 0.
REQ-013 o_dz  output  1  divisor was zero.
REQ-014 o_ovf  output  1  quotient not representable in DW bits.

Function
REQ-015 FSM states: IDLE, CALC, SIGN, DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-016 Accept: on a rising edge with IDLE & i_valid, latch the operand magnitudes and signs, clear the iteration counter, and go to CALC; i_valid is ignored in every other state.
REQ-017 Zero divisor at accept: go directly to DONE; o_dz=1; o_rem=0; o_quot = +(2^(DW-1)-1) if dividend >= 0, else -(2^(DW-1)).
REQ-018 CALC performs one radix-2 restoring step per cycle: shift the partial remainder left by 1 and subtract the divisor magnitude, keeping the difference if it is non-negative; run exactly DW cycles, then go to SIGN.
REQ-019 Partial remainder is VW+1 bits wide, so |divisor| = 2^(VW-1) (-128) divides correctly.
REQ-020 SIGN (1 cycle): negate the quotient if the operand signs differ; negate the remainder if the dividend is negative; evaluate overflow; register the outputs; go to DONE.
REQ-021 Overflow occurs only for dividend = -(2^(DW-1)) with divisor = -1, and sets o_ovf=1.
REQ-022 Latency: o_valid is first high 17 rising edges after, and including, the accepting edge (DW+2); for a zero divisor it is high from the accepting edge.
REQ-023 DONE holds o_valid and all result outputs stable until an edge with i_ready=1, then goes to IDLE; o_ready reasserts the following cycle, so results are never back-to-back.
REQ-024 Outputs o_quot, o_rem, o_dz and o_ovf are registered and change only on the SIGN-to-DONE transition or on the zero-divisor accept.
REQ-025 Operand inputs are don't-care after the accepting edge.

Reset
REQ-026 rst_n low forces IDLE immediately, regardless of clock and including mid-CALC; o_ready=1, o_valid=0, and o_quot, o_rem, o_dz, o_ovf, the counter and all datapath registers are 0.
REQ-027 Any operation in flight at reset is discarded; the first accept after rst_n rises behaves as from power-up.

Configuration
REQ-028 Macro DIV_SAT_EN controls overflow saturation.
REQ-029 With DIV_SAT_EN defined: an overflow result is o_quot = 2^(DW-1)-1 (16383), o_rem = 0, o_ovf = 1.
REQ-030 Without DIV_SAT_EN: an overflow result wraps to o_quot = -(2^(DW-1)) (-16384), o_rem = 0, o_ovf = 1.
REQ-031 The macro affects only the SIGN-state overflow value; latency, handshake and all other results are identical with and without it.

Verification
REQ-032 Dividend -100, divisor 7 -> o_quot=-14, o_rem=-2, o_dz=0, o_ovf=0; o_valid on the 17th edge.
REQ-033 Dividend 16383, divisor 127 -> o_quot=129, o_rem=0; dividend 100, divisor -128 -> o_quot=0, o_rem=100.
REQ-034 Dividend -16384, divisor -1 -> o_ovf=1; o_quot=16383 with DIV_SAT_EN, -16384 without.
REQ-035 Dividend 55, divisor 0 -> o_dz=1, o_quot=16383, o_rem=0, o_valid the cycle after accept; dividend -5, divisor 0 -> o_quot=-16384.
REQ-036 Hold i_ready=0 for 5 cycles in DONE -> o_valid and the outputs stay stable and i_valid pulses are ignored; raise i_ready -> IDLE, and o_ready=1 the next cycle.
REQ-037 Assert rst_n low at CALC cycle 7 -> outputs are 0 and o_ready=1 immediately; a new accept of 20 / 3 -> o_quot=6, o_rem=2.
